// File: rtl/vrf_pkg.sv
// Shared definitions for the lane-partitioned vector register file (VRF) masters.
//
// A vector index is encoded {lane, addr}: the top lane-width bits pick the VRF lane and
// the low addr-width bits pick the entry inside that lane. Both the load writer and the
// store reader use the same split, so the width helpers live here.
//
// Contents: controller state enum and width helper functions (no ports).
package vrf_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StWrite
  } vrf_state_e;

  // Bits needed to name any vector in a VRF of els vectors.
  function automatic int unsigned vrf_vreg_width(input int unsigned els);
    return $clog2(els);
  endfunction

  // Bits of the per-lane entry address (low part of the vector index).
  function automatic int unsigned vrf_addr_width(input int unsigned els, input int unsigned lanes);
    return $clog2(els / lanes);
  endfunction

  // Bits of the lane select (high part of the vector index).
  function automatic int unsigned vrf_lane_width(input int unsigned lanes);
    return $clog2(lanes);
  endfunction

endpackage

// File: rtl/vrf_elem_packer.sv
// Element packer: gathers a stream of vdw_p-bit elements into one vlen_p-element vector.
//
// Ports:
//   clk_i, reset_n_i  clock, asynchronous active-low reset
//   clear_i           restart at slot 0 (start of a new command)
//   en_i              store data_i at the current slot and advance
//   data_i            element data
//   last_o            current slot is the final one of the vector
//   buf_o             packed vector, slot k at bits [k*vdw_p +: vdw_p]
module vrf_elem_packer #(
  parameter int unsigned vlen_p = 8,
  parameter int unsigned vdw_p  = 32
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    clear_i,
  input  logic                    en_i,
  input  logic [vdw_p-1:0]        data_i,
  output logic                    last_o,
  output logic [vlen_p*vdw_p-1:0] buf_o
);

  localparam int unsigned CntWidth = $clog2(vlen_p);

  logic [CntWidth-1:0]     elem_cnt_q;
  logic [vlen_p*vdw_p-1:0] buf_q;

  // vlen_p is a power of two, so the counter wraps to 0 after the last slot by itself.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      elem_cnt_q <= '0;
      buf_q      <= '0;
    end else if (clear_i) begin
      elem_cnt_q <= '0;
    end else if (en_i) begin
      elem_cnt_q                          <= elem_cnt_q + CntWidth'(1);
      buf_q[elem_cnt_q*vdw_p +: vdw_p]    <= data_i;
    end
  end

  assign last_o = (elem_cnt_q == CntWidth'(vlen_p - 1));
  assign buf_o  = buf_q;

endmodule

// File: rtl/vrf_load_writer.sv
// Load writer: write-side master of the lane-partitioned VRF.
//
// Takes a command (first destination vector, vector count minus one), packs vlen_p
// elements of the incoming stream into each vector and writes it to the owning lane in a
// single cycle. Successive vectors go to consecutive indices, wrapping at els_p.
//
// Ports:
//   clk_i, reset_n_i          clock, asynchronous active-low reset
//   cmd_v_i / cmd_ready_o     command handshake; cmd_vreg_i = {lane, addr}, cmd_len_i = count-1
//   in_v_i / in_ready_o       element stream handshake, in_data_i element
//   w_addr_o, w_data_o        per-lane VRF write address / data (same value on every lane)
//   w_en_o                    per-lane write enable, one-hot during the write cycle
//   done_o                    pulses with the last vector write of a command
module vrf_load_writer
  import vrf_pkg::*;
#(
  parameter int unsigned els_p   = 32,
  parameter int unsigned vlen_p  = 8,
  parameter int unsigned vdw_p   = 32,
  parameter int unsigned lanes_p = 4,
  localparam int unsigned vreg_width_lp    = vrf_vreg_width(els_p),
  localparam int unsigned addr_width_lp    = vrf_addr_width(els_p, lanes_p),
  localparam int unsigned lane_width_lp    = vrf_lane_width(lanes_p),
  localparam int unsigned rw_data_width_lp = vlen_p * vdw_p
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,
  input  logic                                  cmd_v_i,
  output logic                                  cmd_ready_o,
  input  logic [vreg_width_lp-1:0]              cmd_vreg_i,
  input  logic [vreg_width_lp-1:0]              cmd_len_i,
  input  logic                                  in_v_i,
  output logic                                  in_ready_o,
  input  logic [vdw_p-1:0]                      in_data_i,
  output logic [lanes_p*addr_width_lp-1:0]      w_addr_o,
  output logic [lanes_p*rw_data_width_lp-1:0]   w_data_o,
  output logic [lanes_p-1:0]                    w_en_o,
  output logic                                  done_o
);

  vrf_state_e                state_q, state_d;
  logic [vreg_width_lp-1:0]  cur_vreg_q, cur_vreg_d;
  logic [vreg_width_lp-1:0]  vec_left_q, vec_left_d;

  logic                        pack_clear;
  logic                        pack_en;
  logic                        pack_last;
  logic [rw_data_width_lp-1:0] pack_buf;

  logic [lane_width_lp-1:0]  cur_lane;
  logic [addr_width_lp-1:0]  cur_addr;

  assign cur_lane = cur_vreg_q[vreg_width_lp-1 -: lane_width_lp];
  assign cur_addr = cur_vreg_q[addr_width_lp-1:0];

  assign cmd_ready_o = (state_q == StIdle);
  assign in_ready_o  = (state_q == StFill);
  assign pack_en     = in_v_i && in_ready_o;

  vrf_elem_packer #(
    .vlen_p (vlen_p),
    .vdw_p  (vdw_p)
  ) u_packer (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (pack_clear),
    .en_i      (pack_en),
    .data_i    (in_data_i),
    .last_o    (pack_last),
    .buf_o     (pack_buf)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= StIdle;
      cur_vreg_q <= '0;
      vec_left_q <= '0;
    end else begin
      state_q    <= state_d;
      cur_vreg_q <= cur_vreg_d;
      vec_left_q <= vec_left_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_vreg_d = cur_vreg_q;
    vec_left_d = vec_left_q;
    pack_clear = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_v_i) begin
          cur_vreg_d = cmd_vreg_i;
          vec_left_d = cmd_len_i;
          pack_clear = 1'b1;
          state_d    = StFill;
        end
      end
      StFill: begin
        if (pack_en && pack_last) begin
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (vec_left_q == '0) begin
          state_d = StIdle;
        end else begin
          vec_left_d = vec_left_q - vreg_width_lp'(1);
          // Natural wrap at vreg_width_lp bits takes els_p-1 back to vector 0.
          cur_vreg_d = cur_vreg_q + vreg_width_lp'(1);
          state_d    = StFill;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    w_en_o = '0;
    if (state_q == StWrite) begin
      w_en_o[cur_lane] = 1'b1;
    end
  end

  assign done_o   = (state_q == StWrite) && (vec_left_q == '0);
  assign w_addr_o = {lanes_p{cur_addr}};
  assign w_data_o = {lanes_p{pack_buf}};

endmodule

// File: tb/tb_vrf_load_writer.sv
module tb_vrf_load_writer;

  localparam int unsigned ElsP   = 32;
  localparam int unsigned VlenP  = 8;
  localparam int unsigned VdwP   = 32;
  localparam int unsigned LanesP = 4;
  localparam int unsigned VregW  = 5;
  localparam int unsigned AddrW  = 3;
  localparam int unsigned RwW    = VlenP * VdwP;

  logic                      clk_i = 1'b0;
  logic                      reset_n = 1'b0;
  logic                      cmd_v_i = 1'b0;
  logic                      cmd_ready_o;
  logic [VregW-1:0]          cmd_vreg_i = '0;
  logic [VregW-1:0]          cmd_len_i = '0;
  logic                      in_v_i = 1'b0;
  logic                      in_ready_o;
  logic [VdwP-1:0]           in_data_i = '0;
  logic [LanesP*AddrW-1:0]   w_addr_o;
  logic [LanesP*RwW-1:0]     w_data_o;
  logic [LanesP-1:0]         w_en_o;
  logic                      done_o;

  vrf_load_writer #(
    .els_p   (ElsP),
    .vlen_p  (VlenP),
    .vdw_p   (VdwP),
    .lanes_p (LanesP)
  ) dut (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n),
    .cmd_v_i     (cmd_v_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_vreg_i  (cmd_vreg_i),
    .cmd_len_i   (cmd_len_i),
    .in_v_i      (in_v_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .w_addr_o    (w_addr_o),
    .w_data_o    (w_data_o),
    .w_en_o      (w_en_o),
    .done_o      (done_o)
  );

  always #5 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;

  // Observation records.
  int                cyc = 0;
  int                acc_n = 0;
  int                bad_rdy = 0;
  int                bad_done = 0;
  int                hs_cyc_q[$];
  int                acc_cyc_q[$];
  int                wr_cyc_q[$];
  logic [LanesP-1:0] wr_en_q[$];
  logic [AddrW-1:0]  wr_addr_q[$];
  logic [RwW-1:0]    wr_data_q[$];
  logic              wr_done_q[$];

  always @(posedge clk_i) begin
    if (reset_n && cmd_v_i && cmd_ready_o) hs_cyc_q.push_back(cyc);
    if (reset_n && in_v_i && in_ready_o) begin
      acc_cyc_q.push_back(cyc);
      acc_n <= acc_n + 1;
    end
    cyc <= cyc + 1;
  end

  function automatic int lane_of(input logic [LanesP-1:0] en);
    int r = 0;
    for (int l = 0; l < int'(LanesP); l++) if (en[l]) r = l;
    return r;
  endfunction

  always @(negedge clk_i) begin
    if (w_en_o != '0) begin
      wr_cyc_q.push_back(cyc);
      wr_en_q.push_back(w_en_o);
      wr_addr_q.push_back(w_addr_o[lane_of(w_en_o)*AddrW +: AddrW]);
      wr_data_q.push_back(w_data_o[lane_of(w_en_o)*RwW +: RwW]);
      wr_done_q.push_back(done_o);
      if (in_ready_o) bad_rdy <= bad_rdy + 1;
    end else if (done_o) begin
      bad_done <= bad_done + 1;
    end
  end

  task automatic check(input string tag, input logic [RwW-1:0] obs, input logic [RwW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [RwW-1:0] mkvec(input int base);
    logic [RwW-1:0] v;
    for (int k = 0; k < int'(VlenP); k++) v[k*VdwP +: VdwP] = VdwP'(base + k);
    return v;
  endfunction

  // Called at a negedge; returns at the negedge after the handshake with cmd_v_i low.
  task automatic send_cmd(input int vreg, input int len);
    int n = 0;
    cmd_v_i    = 1'b1;
    cmd_vreg_i = VregW'(vreg);
    cmd_len_i  = VregW'(len);
    while (!cmd_ready_o && n < 500) begin
      @(negedge clk_i);
      n++;
    end
    check("cmd_hs_timeout", RwW'(cmd_ready_o), RwW'(1));
    @(negedge clk_i);
    cmd_v_i = 1'b0;
  endtask

  // Called at a negedge; feeds n elements base, base+1, ...
  task automatic feed(input int base, input int n, input bit gappy, input bit keep);
    int i = 0;
    int c = 0;
    while (i < n && c < 3000) begin
      in_v_i    = gappy ? 1'($urandom_range(1, 0)) : 1'b1;
      in_data_i = VdwP'(base + i);
      if (in_v_i && in_ready_o) i++;
      @(negedge clk_i);
      c++;
    end
    check("feed_timeout", RwW'(i), RwW'(n));
    in_v_i = keep;
  endtask

  task automatic wait_wr(input int n);
    int c = 0;
    while (wr_en_q.size() < n && c < 200) begin
      @(negedge clk_i);
      c++;
    end
    check("write_timeout", RwW'(wr_en_q.size()), RwW'(n));
  endtask

  task automatic chk_wr(input int idx, input logic [LanesP-1:0] en, input int addr,
                        input int base, input logic done);
    check("wr_en", RwW'(wr_en_q[idx]), RwW'(en));
    check("wr_addr", RwW'(wr_addr_q[idx]), RwW'(addr));
    check("wr_data", wr_data_q[idx], mkvec(base));
    check("wr_done", RwW'(wr_done_q[idx]), RwW'(done));
  endtask

  int a0;
  int h0;

  initial begin
    // Reset state.
    repeat (3) @(negedge clk_i);
    reset_n = 1'b1;
    @(negedge clk_i);
    check("rst_cmd_ready", RwW'(cmd_ready_o), RwW'(1));
    check("rst_in_ready", RwW'(in_ready_o), RwW'(0));
    check("rst_w_en", RwW'(w_en_o), RwW'(0));
    check("rst_done", RwW'(done_o), RwW'(0));
    check("rst_w_addr", RwW'(w_addr_o), RwW'(0));
    check("rst_w_data", RwW'(|w_data_o), RwW'(0));

    // Single vector to vreg 5, with latency checks.
    send_cmd(5, 0);
    feed(32'h10, 8, 1'b0, 1'b0);
    wait_wr(1);
    chk_wr(0, 4'b0001, 5, 32'h10, 1'b1);
    check("first_accept_lat", RwW'(acc_cyc_q[0]), RwW'(hs_cyc_q[0] + 1));
    check("accept_back2back", RwW'(acc_cyc_q[7] - acc_cyc_q[0]), RwW'(7));
    check("write_lat", RwW'(wr_cyc_q[0]), RwW'(acc_cyc_q[7] + 1));
    @(negedge clk_i);
    check("ready_after_done", RwW'(cmd_ready_o), RwW'(1));
    check("no_write_after_done", RwW'(w_en_o), RwW'(0));

    // Three vectors crossing from lane 0 into lane 1.
    send_cmd(7, 2);
    feed(32'h20, 24, 1'b0, 1'b0);
    wait_wr(4);
    chk_wr(1, 4'b0001, 7, 32'h20, 1'b0);
    chk_wr(2, 4'b0010, 0, 32'h28, 1'b0);
    chk_wr(3, 4'b0010, 1, 32'h30, 1'b1);

    // Wrap from vreg 31 to vreg 0.
    @(negedge clk_i);
    send_cmd(31, 1);
    feed(32'h40, 16, 1'b0, 1'b0);
    wait_wr(6);
    chk_wr(4, 4'b1000, 7, 32'h40, 1'b0);
    chk_wr(5, 4'b0001, 0, 32'h48, 1'b1);

    // Random stalls, in_v_i left high through WRITE and IDLE.
    @(negedge clk_i);
    a0 = acc_n;
    send_cmd(3, 1);
    feed(32'h60, 16, 1'b1, 1'b1);
    wait_wr(8);
    in_data_i = 32'hDEAD_BEEF;
    repeat (5) @(negedge clk_i);
    check("stall_accept_cnt", RwW'(acc_n - a0), RwW'(16));
    check("idle_w_en", RwW'(w_en_o), RwW'(0));
    in_v_i = 1'b0;
    chk_wr(6, 4'b0001, 3, 32'h60, 1'b0);
    chk_wr(7, 4'b0001, 4, 32'h68, 1'b1);

    // Reset with a half-filled vector.
    send_cmd(6, 0);
    feed(32'hB0, 4, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk_i);
    reset_n = 1'b1;
    repeat (12) @(negedge clk_i);
    check("rst_mid_no_write", RwW'(wr_en_q.size()), RwW'(8));
    check("rst_mid_cmd_ready", RwW'(cmd_ready_o), RwW'(1));
    check("rst_mid_w_data", RwW'(|w_data_o), RwW'(0));
    check("rst_mid_w_addr", RwW'(w_addr_o), RwW'(0));
    send_cmd(2, 0);
    feed(32'hA0, 8, 1'b0, 1'b0);
    wait_wr(9);
    chk_wr(8, 4'b0001, 2, 32'hA0, 1'b1);

    // Second command held high throughout the first one.
    @(negedge clk_i);
    h0 = hs_cyc_q.size();
    send_cmd(9, 0);
    cmd_v_i    = 1'b1;
    cmd_vreg_i = 5'd12;
    cmd_len_i  = 5'd0;
    feed(32'hC0, 8, 1'b0, 1'b0);
    wait_wr(10);
    for (int c = 0; c < 20 && hs_cyc_q.size() < h0 + 2; c++) @(negedge clk_i);
    cmd_v_i = 1'b0;
    check("b2b_hs_count", RwW'(hs_cyc_q.size()), RwW'(h0 + 2));
    check("b2b_hs_cycle", RwW'(hs_cyc_q[h0 + 1]), RwW'(wr_cyc_q[9] + 1));
    chk_wr(9, 4'b0010, 1, 32'hC0, 1'b1);
    feed(32'hD0, 8, 1'b0, 1'b0);
    wait_wr(11);
    chk_wr(10, 4'b0010, 4, 32'hD0, 1'b1);

    repeat (3) @(negedge clk_i);
    check("total_writes", RwW'(wr_en_q.size()), RwW'(11));
    check("in_ready_in_write", RwW'(bad_rdy), RwW'(0));
    check("done_outside_write", RwW'(bad_done), RwW'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
